// File: rtl/fetch_mem_responder_if.sv
// Fetch/LSU request-response bundle between the core and the unified memory responder.
// master = requester side (core), slave = memory responder.
interface fetch_mem_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_req_valid;
    logic                  fetch_grant;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  fetch_data_valid;
    logic                  fetch_err;
    logic                  flush;
    logic                  lsu_req;
    logic                  lsu_we;
    logic [ADDR_WIDTH-1:0] lsu_addr;
    logic [DATA_WIDTH-1:0] lsu_wdata;
    logic [DATA_WIDTH-1:0] lsu_rdata;
    logic                  lsu_ack;

    modport master (
        output fetch_addr, fetch_req_valid, flush, lsu_req, lsu_we, lsu_addr, lsu_wdata,
        input  fetch_grant, fetch_data, fetch_data_valid, fetch_err, lsu_rdata, lsu_ack
    );

    modport slave (
        input  fetch_addr, fetch_req_valid, flush, lsu_req, lsu_we, lsu_addr, lsu_wdata,
        output fetch_grant, fetch_data, fetch_data_valid, fetch_err, lsu_rdata, lsu_ack
    );
endinterface

// File: rtl/fetch_mem_responder.sv
// Unified single-port memory serving the fetch port and a higher-priority LSU port, fixed latency.
// Optional macro FETCH_MISALIGN_CHK_EN: misaligned/out-of-range fetches return a NOP with fetch_err.
module fetch_mem_responder #(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_DEPTH    = 1024
) (
    input  logic                        clk,
    input  logic                        reset_n,
    fetch_mem_responder_if.slave        bus,
    output logic                        busy
);
    localparam int unsigned Words = MEM_DEPTH / 4;
    localparam int unsigned IdxW  = $clog2(MEM_DEPTH) - 2;

    typedef enum logic [1:0] {StIdle, StFBusy, StFResp, StLBusy} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
    logic                  fetch_valid_q, fetch_valid_d;
    logic                  fetch_err_q, fetch_err_d;
    logic [DATA_WIDTH-1:0] lsu_rdata_q, lsu_rdata_d;
    logic                  lsu_ack_q, lsu_ack_d;

    logic [DATA_WIDTH-1:0] mem_q [Words];
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_we;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [IdxW-1:0]       cur_idx;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  grant, fetch_done, lsu_done, mem_we;

    // With READ_LATENCY == 1 a transaction completes on its accept edge, so use live inputs.
    always_comb begin
        if (state_q == StIdle) begin
            cur_addr  = bus.lsu_req ? bus.lsu_addr : bus.fetch_addr;
            cur_we    = bus.lsu_we;
            cur_wdata = bus.lsu_wdata;
        end else begin
            cur_addr  = addr_q;
            cur_we    = we_q;
            cur_wdata = wdata_q;
        end
        cur_idx   = cur_addr[IdxW+1:2];
        mem_rdata = mem_q[cur_idx];
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        fetch_data_d  = fetch_data_q;
        fetch_valid_d = fetch_valid_q;
        fetch_err_d   = fetch_err_q;
        lsu_rdata_d   = lsu_rdata_q;
        lsu_ack_d     = 1'b0;
        grant         = 1'b0;
        fetch_done    = 1'b0;
        lsu_done      = 1'b0;
        mem_we        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.lsu_req) begin
                    addr_d  = bus.lsu_addr;
                    we_d    = bus.lsu_we;
                    wdata_d = bus.lsu_wdata;
                    cnt_d   = 4'(READ_LATENCY - 1);
                    state_d = StLBusy;
                    if (READ_LATENCY == 1) lsu_done = 1'b1;
                end else if (bus.fetch_req_valid && !bus.flush) begin
                    grant  = 1'b1;
                    addr_d = bus.fetch_addr;
                    cnt_d  = 4'(READ_LATENCY - 1);
                    if (READ_LATENCY == 1) begin
                        fetch_done = 1'b1;
                        state_d    = StFResp;
                    end else begin
                        state_d = StFBusy;
                    end
                end
            end
            StFBusy: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else if (cnt_q <= 4'd1) begin
                    fetch_done = 1'b1;
                    state_d    = StFResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StFResp: begin
                if (!bus.fetch_req_valid || bus.flush || (bus.fetch_addr != addr_q)) begin
                    state_d       = StIdle;
                    fetch_valid_d = 1'b0;
                    fetch_err_d   = 1'b0;
                end
            end
            StLBusy: begin
                if (lsu_ack_q) begin
                    state_d = StIdle;
                end else if (cnt_q <= 4'd1) begin
                    lsu_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase

        if (fetch_done) begin
            cnt_d         = 4'd0;
            fetch_valid_d = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
            if ((cur_addr[1:0] != 2'b00) || (cur_addr >= ADDR_WIDTH'(MEM_DEPTH))) begin
                fetch_data_d = DATA_WIDTH'(32'h0000_0013);
                fetch_err_d  = 1'b1;
            end else begin
                fetch_data_d = mem_rdata;
                fetch_err_d  = 1'b0;
            end
`else
            fetch_data_d = mem_rdata;
            fetch_err_d  = 1'b0;
`endif
        end

        if (lsu_done) begin
            cnt_d     = 4'd0;
            lsu_ack_d = 1'b1;
            mem_we    = cur_we;
            if (!cur_we) lsu_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            fetch_data_q  <= '0;
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            lsu_rdata_q   <= '0;
            lsu_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            fetch_data_q  <= fetch_data_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_err_q   <= fetch_err_d;
            lsu_rdata_q   <= lsu_rdata_d;
            lsu_ack_q     <= lsu_ack_d;
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[cur_idx] <= cur_wdata;
    end

    assign bus.fetch_grant      = grant;
    assign bus.fetch_data       = fetch_data_q;
    assign bus.fetch_data_valid = fetch_valid_q;
    assign bus.fetch_err        = fetch_err_q;
    assign bus.lsu_rdata        = lsu_rdata_q;
    assign bus.lsu_ack          = lsu_ack_q;
    assign busy                 = (state_q != StIdle);
endmodule

// File: tb/tb_fetch_mem_responder.sv
// Directed bench for fetch_mem_responder (READ_LATENCY=2); expectations follow FETCH_MISALIGN_CHK_EN.
module tb_fetch_mem_responder;
    logic clk;
    logic reset_n;
    logic busy;
    int   total;
    int   bad;

    fetch_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    fetch_mem_responder #(
        .READ_LATENCY(2),
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_DEPTH   (1024)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic lsu_wr(input logic [31:0] a, input logic [31:0] d);
        bus.lsu_req   = 1'b1;
        bus.lsu_we    = 1'b1;
        bus.lsu_addr  = a;
        bus.lsu_wdata = d;
        tick();
        bus.lsu_req = 1'b0;
        bus.lsu_we  = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n             = 1'b0;
        bus.fetch_addr      = '0;
        bus.fetch_req_valid = 1'b0;
        bus.flush           = 1'b0;
        bus.lsu_req         = 1'b0;
        bus.lsu_we          = 1'b0;
        bus.lsu_addr        = '0;
        bus.lsu_wdata       = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.fetch_data_valid), 32'd0);
        chk("rst_data", bus.fetch_data, 32'd0);
        chk("rst_ack", 32'(bus.lsu_ack), 32'd0);
        chk("rst_rdata", bus.lsu_rdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(bus.fetch_err), 32'd0);
        reset_n = 1'b1;

        // Preload: word1 with LSU ack timing checked, plus words 0 and 4 for later steps.
        bus.lsu_req   = 1'b1;
        bus.lsu_we    = 1'b1;
        bus.lsu_addr  = 32'd4;
        bus.lsu_wdata = 32'hDEAD_BEEF;
        tick();
        chk("wr_busy", 32'(busy), 32'd1);
        chk("wr_ack_early", 32'(bus.lsu_ack), 32'd0);
        bus.lsu_req = 1'b0;
        bus.lsu_we  = 1'b0;
        tick();
        chk("wr_ack", 32'(bus.lsu_ack), 32'd1);
        tick();
        chk("wr_ack_pulse", 32'(bus.lsu_ack), 32'd0);
        chk("wr_idle", 32'(busy), 32'd0);
        lsu_wr(32'd0, 32'h0000_00A5);
        lsu_wr(32'd16, 32'hCAFE_0010);

        // 1: basic fetch, hold, release
        bus.fetch_req_valid = 1'b1;
        bus.fetch_addr      = 32'd4;
        #1;
        chk("t1_grant", 32'(bus.fetch_grant), 32'd1);
        tick();
        chk("t1_no_grant_busy", 32'(bus.fetch_grant), 32'd0);
        chk("t1_not_valid", 32'(bus.fetch_data_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(bus.fetch_data_valid), 32'd1);
        chk("t1_data", bus.fetch_data, 32'hDEAD_BEEF);
        tick();
        chk("t1_hold", 32'(bus.fetch_data_valid), 32'd1);
        bus.fetch_req_valid = 1'b0;
        tick();
        chk("t1_drop", 32'(bus.fetch_data_valid), 32'd0);
        chk("t1_data_kept", bus.fetch_data, 32'hDEAD_BEEF);

        // 2: LSU priority over simultaneous fetch
        bus.lsu_req         = 1'b1;
        bus.lsu_we          = 1'b1;
        bus.lsu_addr        = 32'd8;
        bus.lsu_wdata       = 32'h1234_5678;
        bus.fetch_req_valid = 1'b1;
        bus.fetch_addr      = 32'd0;
        #1;
        chk("t2_no_grant", 32'(bus.fetch_grant), 32'd0);
        tick();
        bus.lsu_req = 1'b0;
        bus.lsu_we  = 1'b0;
        #1;
        chk("t2_no_grant_lbusy", 32'(bus.fetch_grant), 32'd0);
        tick();
        chk("t2_ack", 32'(bus.lsu_ack), 32'd1);
        chk("t2_no_grant_ack", 32'(bus.fetch_grant), 32'd0);
        tick();
        chk("t2_grant_after", 32'(bus.fetch_grant), 32'd1);
        tick();
        tick();
        chk("t2_valid0", 32'(bus.fetch_data_valid), 32'd1);
        chk("t2_data0", bus.fetch_data, 32'h0000_00A5);
        bus.fetch_addr = 32'd8;
        tick();
        chk("t2_retarget_drop", 32'(bus.fetch_data_valid), 32'd0);
        chk("t2_grant8", 32'(bus.fetch_grant), 32'd1);
        tick();
        tick();
        chk("t2_valid8", 32'(bus.fetch_data_valid), 32'd1);
        chk("t2_data8", bus.fetch_data, 32'h1234_5678);
        bus.fetch_req_valid = 1'b0;
        tick();
        bus.lsu_req  = 1'b1;
        bus.lsu_we   = 1'b0;
        bus.lsu_addr = 32'd8;
        tick();
        bus.lsu_req = 1'b0;
        tick();
        chk("t2_rd_ack", 32'(bus.lsu_ack), 32'd1);
        chk("t2_rd_data", bus.lsu_rdata, 32'h1234_5678);
        tick();

        // 3: flush in IDLE, in F_BUSY, in F_RESP
        bus.fetch_req_valid = 1'b1;
        bus.fetch_addr      = 32'd4;
        bus.flush           = 1'b1;
        #1;
        chk("t3_flush_idle", 32'(bus.fetch_grant), 32'd0);
        bus.flush = 1'b0;
        #1;
        chk("t3_grant", 32'(bus.fetch_grant), 32'd1);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        chk("t3_killed", 32'(bus.fetch_data_valid), 32'd0);
        chk("t3_regrant", 32'(bus.fetch_grant), 32'd1);
        tick();
        chk("t3_busy_nv", 32'(bus.fetch_data_valid), 32'd0);
        tick();
        chk("t3_valid", 32'(bus.fetch_data_valid), 32'd1);
        chk("t3_data", bus.fetch_data, 32'hDEAD_BEEF);
        bus.flush = 1'b1;
        tick();
        chk("t3_resp_flush", 32'(bus.fetch_data_valid), 32'd0);
        chk("t3_resp_flush_ng", 32'(bus.fetch_grant), 32'd0);
        bus.flush           = 1'b0;
        bus.fetch_req_valid = 1'b0;
        tick();

        // 4: hold response, retarget, LSU blocked behind F_RESP
        bus.fetch_req_valid = 1'b1;
        bus.fetch_addr      = 32'd0;
        #1;
        chk("t4_grant", 32'(bus.fetch_grant), 32'd1);
        tick();
        tick();
        chk("t4_data", bus.fetch_data, 32'h0000_00A5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4_hold%0d", i), 32'(bus.fetch_data_valid), 32'd1);
            if (i < 4) tick();
        end
        bus.fetch_addr = 32'd16;
        tick();
        chk("t4_retarget_drop", 32'(bus.fetch_data_valid), 32'd0);
        chk("t4_grant16", 32'(bus.fetch_grant), 32'd1);
        tick();
        tick();
        chk("t4_valid16", 32'(bus.fetch_data_valid), 32'd1);
        chk("t4_data16", bus.fetch_data, 32'hCAFE_0010);
        bus.lsu_req  = 1'b1;
        bus.lsu_we   = 1'b0;
        bus.lsu_addr = 32'd4;
        tick();
        chk("t4_lsu_blocked", 32'(bus.lsu_ack), 32'd0);
        chk("t4_resp_held", 32'(bus.fetch_data_valid), 32'd1);
        bus.fetch_req_valid = 1'b0;
        tick();
        chk("t4_exit_valid", 32'(bus.fetch_data_valid), 32'd0);
        chk("t4_exit_idle", 32'(busy), 32'd0);
        tick();
        bus.lsu_req = 1'b0;
        chk("t4_lsu_busy", 32'(busy), 32'd1);
        tick();
        chk("t4_lsu_ack", 32'(bus.lsu_ack), 32'd1);
        chk("t4_lsu_rdata", bus.lsu_rdata, 32'hDEAD_BEEF);
        tick();
        chk("t4_lsu_done", 32'(bus.lsu_ack), 32'd0);

        // 5: async reset during F_BUSY
        bus.fetch_req_valid = 1'b1;
        bus.fetch_addr      = 32'd4;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_data", bus.fetch_data, 32'd0);
        chk("t5_rdata", bus.lsu_rdata, 32'd0);
        bus.fetch_req_valid = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        tick();
        chk("t5_no_resp_a", 32'(bus.fetch_data_valid), 32'd0);
        tick();
        chk("t5_no_resp_b", 32'(bus.fetch_data_valid), 32'd0);
        bus.fetch_req_valid = 1'b1;
        bus.fetch_addr      = 32'd4;
        tick();
        tick();
        chk("t5_mem_kept", bus.fetch_data, 32'hDEAD_BEEF);
        bus.fetch_req_valid = 1'b0;
        tick();

        // 6: misaligned and out-of-range fetches
        bus.fetch_req_valid = 1'b1;
        bus.fetch_addr      = 32'd6;
        tick();
        tick();
        chk("t6_mis_valid", 32'(bus.fetch_data_valid), 32'd1);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("t6_mis_data", bus.fetch_data, 32'h0000_0013);
        chk("t6_mis_err", 32'(bus.fetch_err), 32'd1);
`else
        chk("t6_mis_data", bus.fetch_data, 32'hDEAD_BEEF);
        chk("t6_mis_err", 32'(bus.fetch_err), 32'd0);
`endif
        bus.fetch_req_valid = 1'b0;
        tick();
        chk("t6_err_clear", 32'(bus.fetch_err), 32'd0);
        bus.fetch_req_valid = 1'b1;
        bus.fetch_addr      = 32'd1032;
        tick();
        tick();
`ifdef FETCH_MISALIGN_CHK_EN
        chk("t6_oor_data", bus.fetch_data, 32'h0000_0013);
        chk("t6_oor_err", 32'(bus.fetch_err), 32'd1);
`else
        chk("t6_wrap_data", bus.fetch_data, 32'h1234_5678);
        chk("t6_wrap_err", 32'(bus.fetch_err), 32'd0);
`endif
        bus.fetch_req_valid = 1'b0;
        tick();
        chk("t6_end_valid", 32'(bus.fetch_data_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
